// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler that shares one multi-cycle integer
// comparator among NUM_REQ requesters. Each request is accepted through a
// valid/ready handshake and issued to the comparator. After the comparator's
// fixed latency, its result is returned to the requester as a one-cycle
// response pulse.
//
// Optional feature: define CMP_SCHED_EQ_BYPASS_EN to answer bitwise-equal
// operands directly with result 00, without using the comparator.
module cmp_sched #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned CMP_LATENCY = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [1:0]                 rsp_result,
   output logic                       busy,
   output logic                       cmp_execute,
   output logic [WIDTH-1:0]           cmp_a,
   output logic [WIDTH-1:0]           cmp_b,
   input  logic [1:0]                 cmp_result
);

   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(CMP_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant;
   logic [CNT_W-1:0]   wait_cnt;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    idx;
   logic [WIDTH-1:0]   win_a;
   logic [WIDTH-1:0]   win_b;

   // Round-robin search: first valid requester starting at rr_ptr
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Operand mux for the current winner
   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            win_a = req_a[i*WIDTH +: WIDTH];
            win_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Grant is offered only while idle; suppressed during reset so no handshake is lost
   assign req_ready = (state == ST_IDLE && win_found && !reset)
                      ? (NUM_REQ'(1) << win_id) : '0;

   // Scheduler FSM with registered comparator and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant       <= '0;
         wait_cnt    <= '0;
         rsp_valid   <= '0;
         rsp_result  <= 2'b00;
         busy        <= 1'b0;
         cmp_execute <= 1'b0;
         cmp_a       <= '0;
         cmp_b       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  cmp_a <= win_a;
                  cmp_b <= win_b;
                  grant <= win_id;
                  busy  <= 1'b1;
`ifdef CMP_SCHED_EQ_BYPASS_EN
                  if (win_a == win_b) begin
                     rsp_result <= 2'b00;
                     rsp_valid  <= NUM_REQ'(1) << win_id;
                     state      <= ST_DONE;
                  end else begin
                     cmp_execute <= 1'b1;
                     state       <= ST_ISSUE;
                  end
`else
                  cmp_execute <= 1'b1;
                  state       <= ST_ISSUE;
`endif
               end
            end
            ST_ISSUE: begin
               cmp_execute <= 1'b0;
               wait_cnt    <= CNT_W'(CMP_LATENCY);
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
               if (wait_cnt == CNT_W'(1)) begin
                  rsp_result <= cmp_result;
                  rsp_valid  <= NUM_REQ'(1) << grant;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               rsp_valid <= '0;
               busy      <= 1'b0;
               rr_ptr    <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: directed self-checking bench for cmp_sched, using a
// behavioural fixed-latency signed comparator.
module tb_cmp_sched;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;
   localparam int unsigned L = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     rsp_valid;
   logic [1:0]       rsp_result;
   logic             busy;
   logic             cmp_execute;
   logic [W-1:0]     cmp_a;
   logic [W-1:0]     cmp_b;
   logic [1:0]       cmp_result;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cmp_sched #(.NUM_REQ(N), .WIDTH(W), .CMP_LATENCY(L)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_result  (rsp_result),
      .busy        (busy),
      .cmp_execute (cmp_execute),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_result  (cmp_result)
   );

   // Comparator model: result valid only in the last cycle of its latency window
   logic [2:0] m_cnt = 3'd0;
   logic [1:0] m_res = 2'b10;
   always @(posedge clk) begin
      if (cmp_execute) begin
         m_cnt <= 3'(L);
         if (cmp_a == cmp_b)                   m_res <= 2'b00;
         else if ($signed(cmp_a) > $signed(cmp_b)) m_res <= 2'b01;
         else                                  m_res <= 2'b11;
      end else if (m_cnt != 3'd0) begin
         m_cnt <= m_cnt - 3'd1;
      end
   end
   assign cmp_result = (m_cnt == 3'd1) ? m_res : 2'b10;

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // One full non-bypass transaction starting in an IDLE cycle with inputs driven
   task automatic run_op(input logic [N-1:0] exp_g, input logic [1:0] exp_res,
                         input string tag, input bit hold);
      settle();
      chk({tag, " ready"}, W'(req_ready), W'(exp_g));
      next();
      if (!hold) req_valid = req_valid & ~exp_g;
      settle();
      chk({tag, " exec"}, W'(cmp_execute), W'(1));
      for (int c = 2; c <= 5; c++) begin
         next();
         settle();
         chk({tag, " ready_busy"}, W'(req_ready), W'(0));
         if (c == 5) begin
            chk({tag, " rsp_valid"}, W'(rsp_valid), W'(exp_g));
            chk({tag, " rsp_result"}, W'(rsp_result), W'(exp_res));
         end
      end
      next();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (2) next();
      settle();
      chk("rst busy",       W'(busy),        W'(0));
      chk("rst rsp_valid",  W'(rsp_valid),   W'(0));
      chk("rst rsp_result", W'(rsp_result),  W'(0));
      chk("rst exec",       W'(cmp_execute), W'(0));
      chk("rst cmp_a",      cmp_a,           W'(0));
      chk("rst cmp_b",      cmp_b,           W'(0));
      chk("rst ready",      W'(req_ready),   W'(0));
      reset = 1'b0;
      next();

      // Single compare: req0, 5 vs 3
      set_op(0, 32'd5, 32'd3);
      req_valid = 4'b0001;
      settle();
      chk("t1 ready c0", W'(req_ready), W'(4'b0001));
      chk("t1 busy c0",  W'(busy),      W'(0));
      next();
      req_valid = '0;
      settle();
      chk("t1 exec c1",  W'(cmp_execute), W'(1));
      chk("t1 busy c1",  W'(busy),        W'(1));
      chk("t1 cmp_a",    cmp_a,           W'(5));
      chk("t1 cmp_b",    cmp_b,           W'(3));
      next();
      settle();
      chk("t1 exec c2",  W'(cmp_execute), W'(0));
      next();
      next();
      settle();
      chk("t1 rsp c4",   W'(rsp_valid),   W'(0));
      next();
      settle();
      chk("t1 rsp c5",   W'(rsp_valid),   W'(4'b0001));
      chk("t1 res c5",   W'(rsp_result),  W'(2'b01));
      next();
      settle();
      chk("t1 busy c6",  W'(busy),        W'(0));
      chk("t1 rsp c6",   W'(rsp_valid),   W'(0));
      chk("t1 hold res", W'(rsp_result),  W'(2'b01));

      // Signed less-than on req2
      set_op(2, 32'hFFFF_FFFE, 32'd7);
      req_valid = 4'b0100;
      run_op(4'b0100, 2'b11, "slt", 1'b0);

      // Round robin from a fresh reset with all requesters held
      reset = 1'b1;
      next();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, 32'(20 + i), 32'd10);
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) run_op(4'(1 << (g % 4)), 2'b01, "rr", 1'b1);
      req_valid = 4'b0010;
      run_op(4'b0010, 2'b01, "rr_to2", 1'b0);
      req_valid = 4'b1010;
      run_op(4'b1000, 2'b01, "rr_skip", 1'b0);
      run_op(4'b0010, 2'b01, "rr_wrap", 1'b0);

      // No grant while busy: req1 raised during WAIT
      req_valid = 4'b0001;
      settle();
      chk("busy ready c0", W'(req_ready), W'(4'b0001));
      next();
      req_valid = '0;
      next();
      req_valid = 4'b0010;
      settle();
      chk("busy ready c2", W'(req_ready), W'(0));
      next();
      settle();
      chk("busy ready c3", W'(req_ready), W'(0));
      next();
      settle();
      chk("busy ready c4", W'(req_ready), W'(0));
      next();
      settle();
      chk("busy ready c5", W'(req_ready), W'(0));
      chk("busy rsp c5",   W'(rsp_valid), W'(4'b0001));
      next();
      run_op(4'b0010, 2'b01, "late", 1'b0);

      // Reset in the second WAIT cycle
      req_valid = 4'b0100;
      settle();
      chk("mrst ready c0", W'(req_ready), W'(4'b0100));
      next();
      req_valid = '0;
      next();
      next();
      reset = 1'b1;
      next();
      reset = 1'b0;
      settle();
      chk("mrst busy",   W'(busy),        W'(0));
      chk("mrst rsp",    W'(rsp_valid),   W'(0));
      chk("mrst exec",   W'(cmp_execute), W'(0));
      chk("mrst cmp_a",  cmp_a,           W'(0));
      chk("mrst cmp_b",  cmp_b,           W'(0));
      chk("mrst res",    W'(rsp_result),  W'(0));
      for (int c = 0; c < 4; c++) begin
         next();
         settle();
         chk("mrst no rsp", W'(rsp_valid), W'(0));
      end
      req_valid = 4'b1010;
      run_op(4'b0010, 2'b01, "post_rst", 1'b0);
      req_valid = '0;

      // Equal operands on req0 (rr_ptr = 2)
      set_op(0, 32'h1234, 32'h1234);
      req_valid = 4'b0001;
      settle();
      chk("eq ready", W'(req_ready), W'(4'b0001));
      next();
      req_valid = '0;
      settle();
`ifdef CMP_SCHED_EQ_BYPASS_EN
      chk("eq exec c1", W'(cmp_execute), W'(0));
      chk("eq rsp c1",  W'(rsp_valid),   W'(4'b0001));
      chk("eq res c1",  W'(rsp_result),  W'(2'b00));
      chk("eq cmp_a",   cmp_a,           W'(32'h1234));
      next();
      settle();
      chk("eq busy c2", W'(busy),        W'(0));
      chk("eq exec c2", W'(cmp_execute), W'(0));
      chk("eq rsp c2",  W'(rsp_valid),   W'(0));
`else
      chk("eq exec c1", W'(cmp_execute), W'(1));
      chk("eq rsp c1",  W'(rsp_valid),   W'(0));
      for (int c = 2; c <= 4; c++) begin
         next();
         settle();
         chk("eq rsp wait", W'(rsp_valid), W'(0));
      end
      next();
      settle();
      chk("eq rsp c5",  W'(rsp_valid),  W'(4'b0001));
      chk("eq res c5",  W'(rsp_result), W'(2'b00));
      next();
      settle();
      chk("eq busy c6", W'(busy),       W'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
